vram_console: RTL



---
 rtl/vram_console.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vram_console.sv
// rtl/vram_console.sv - text-mode terminal engine turning a byte stream into VRAM character writes
//
// Ports:
//   MEMORY_CLK           system/memory clock
//   rst_n                asynchronous active-low reset
//   in_valid, in_data    producer byte stream (character or control code)
//   in_ready             high only while IDLE; a byte transfers on in_valid && in_ready
//   v_ada, v_din, v_cea  registered VRAM write port A (10-bit address, byte data, one-cycle enable)
//   scroll_top           physical VRAM row shown as screen row 0 (display adds it mod ROWS)
//   cursor_col           current column, 0..COLS-1
//   cursor_row           current logical row, 0..ROWS-1
module vram_console #(
    parameter int          COLS  = 60,
    parameter int          ROWS  = 17,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        MEMORY_CLK,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [9:0]  v_ada,
    output logic [7:0]  v_din,
    output logic        v_cea,
    output logic [4:0]  scroll_top,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row
);

    localparam logic [9:0] LAST_CELL  = 10'(COLS * ROWS - 1);
    localparam logic [9:0] LAST_COL10 = 10'(COLS - 1);
    localparam logic [5:0] LAST_COL   = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        CLEAR_ALL,
        CLEAR_ROW,
        IDLE
    } state_t;

    state_t     state;
    logic [9:0] fill;       // cell index within the current fill
    logic [4:0] clr_row;    // physical row being blanked by CLEAR_ROW

    logic       accept;
    logic       printable;
    logic       wrap;
    logic       newline;
    logic [9:0] row_base;
    logic [9:0] cur_addr;
    logic [9:0] bs_addr;
    logic [4:0] next_top;

    function automatic logic [9:0] row_addr(input logic [4:0] phys_row);
        return 10'(phys_row) * 10'(COLS);
    endfunction

    // Logical row to physical VRAM row; both operands are below ROWS so one
    // conditional subtract is enough.
    function automatic logic [4:0] phys_of(input logic [4:0] top, input logic [4:0] row);
        logic [5:0] sum;
        sum = {1'b0, top} + {1'b0, row};
        if (sum >= 6'(ROWS)) begin
            sum = sum - 6'(ROWS);
        end
        return sum[4:0];
    endfunction

    assign in_ready  = (state == IDLE);
    assign accept    = in_ready && in_valid;
    assign printable = (in_data >= 8'h20);
    assign wrap      = printable && (cursor_col == LAST_COL);
    assign newline   = wrap || (in_data == 8'h0A);
    assign row_base  = row_addr(phys_of(scroll_top, cursor_row));
    assign cur_addr  = row_base + 10'(cursor_col);
    assign bs_addr   = cur_addr - 10'd1;
    assign next_top  = (scroll_top == LAST_ROW) ? 5'd0 : scroll_top + 5'd1;

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR_ALL;
            fill       <= 10'd0;
            clr_row    <= 5'd0;
            v_ada      <= 10'd0;
            v_din      <= 8'd0;
            v_cea      <= 1'b0;
            scroll_top <= 5'd0;
            cursor_col <= 6'd0;
            cursor_row <= 5'd0;
        end else begin
            v_cea <= 1'b0;
            case (state)
                CLEAR_ALL: begin
                    v_cea <= 1'b1;
                    v_ada <= fill;
                    v_din <= BLANK;
                    fill  <= fill + 10'd1;
                    if (fill == LAST_CELL) begin
                        fill  <= 10'd0;
                        state <= IDLE;
                    end
                end
                CLEAR_ROW: begin
                    v_cea <= 1'b1;
                    v_ada <= row_addr(clr_row) + fill;
                    v_din <= BLANK;
                    fill  <= fill + 10'd1;
                    if (fill == LAST_COL10) begin
                        fill  <= 10'd0;
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            v_cea      <= 1'b1;
                            v_ada      <= cur_addr;
                            v_din      <= in_data;
                            cursor_col <= wrap ? 6'd0 : cursor_col + 6'd1;
                        end else begin
                            case (in_data)
                                8'h0A, 8'h0D: cursor_col <= 6'd0;
                                8'h08: begin
                                    if (cursor_col != 6'd0) begin
                                        v_cea      <= 1'b1;
                                        v_ada      <= bs_addr;
                                        v_din      <= BLANK;
                                        cursor_col <= cursor_col - 6'd1;
                                    end
                                end
                                8'h0C: begin
                                    scroll_top <= 5'd0;
                                    cursor_col <= 6'd0;
                                    cursor_row <= 5'd0;
                                    fill       <= 10'd0;
                                    state      <= CLEAR_ALL;
                                end
                                default: ;
                            endcase
                        end
                        // The wrapping character is written this cycle; the row
                        // clear targets the old top row, which is never the row
                        // just written.
                        if (newline) begin
                            if (cursor_row == LAST_ROW) begin
                                scroll_top <= next_top;
                                clr_row    <= scroll_top;
                                fill       <= 10'd0;
                                state      <= CLEAR_ROW;
                            end else begin
                                cursor_row <= cursor_row + 5'd1;
                            end
                        end
                    end
                end
                default: state <= CLEAR_ALL;
            endcase
        end
    end

endmodule
